// File: rtl/n4_b10_down_timer_if.sv
// Control/data bundle for n4_b10_down_timer.
// master: the parent block that presets and enables the timer.
// slave: the timer itself.
interface n4_b10_down_timer_if;
  logic       load;
  logic [3:0] d33_d30;
  logic [3:0] d23_d20;
  logic [3:0] d13_d10;
  logic [3:0] d03_d00;
  logic       ei;
  logic [3:0] q33_q30;
  logic [3:0] q23_q20;
  logic [3:0] q13_q10;
  logic [3:0] q03_q00;
  logic       eu;
  logic       busy;
  logic       done;

  modport master (
    output load, d33_d30, d23_d20, d13_d10, d03_d00, ei,
    input  q33_q30, q23_q20, q13_q10, q03_q00, eu, busy, done
  );

  modport slave (
    input  load, d33_d30, d23_d20, d13_d10, d03_d00, ei,
    output q33_q30, q23_q20, q13_q10, q03_q00, eu, busy, done
  );
endinterface

// File: rtl/n4_b10_down_timer.sv
// 4-digit BCD presettable down timer (0000-9999) with IDLE/RUN/DONE control.
// Optional feature macro: N4_B10_DOWN_TIMER_AUTORELOAD_EN keeps a copy of the
// last preset and restarts from it after each expiry.
module n4_b10_down_timer (
  input  logic                  clock,
  input  logic                  reset_,
  n4_b10_down_timer_if.slave    bus
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2} state_e;

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] preset_san;
  logic [15:0] count_dec;

`ifdef N4_B10_DOWN_TIMER_AUTORELOAD_EN
  logic [15:0] preset_q;
`endif

  // Clamp a non-decimal digit to 9.
  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Sanitise each preset digit independently.
  always_comb begin
    preset_san = {sat_digit(bus.d33_d30), sat_digit(bus.d23_d20),
                  sat_digit(bus.d13_d10), sat_digit(bus.d03_d00)};
  end

  // BCD decrement with borrow rippling from units towards thousands.
  always_comb begin
    logic       borrow;
    logic [3:0] digit;
    count_dec = count_q;
    borrow    = 1'b1;
    digit     = 4'd0;
    for (int i = 0; i < 4; i++) begin
      digit = count_q[4*i +: 4];
      if (borrow) begin
        if (digit == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = digit - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  // Control FSM and count register; load overrides every state.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q  <= StIdle;
      count_q  <= '0;
`ifdef N4_B10_DOWN_TIMER_AUTORELOAD_EN
      preset_q <= '0;
`endif
    end else if (bus.load) begin
      count_q  <= preset_san;
      state_q  <= (preset_san != 16'h0000) ? StRun : StDone;
`ifdef N4_B10_DOWN_TIMER_AUTORELOAD_EN
      preset_q <= preset_san;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (bus.ei) begin
            // Terminal step: land on 0000 and report expiry next cycle.
            if (count_q == 16'h0001) begin
              count_q <= '0;
              state_q <= StDone;
            end else begin
              count_q <= count_dec;
            end
          end
        end
        StDone: begin
`ifdef N4_B10_DOWN_TIMER_AUTORELOAD_EN
          // A zero copy must not loop through DONE forever.
          if (preset_q != 16'h0000) begin
            count_q <= preset_q;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode; eu is combinational so chained timers see it in the same cycle.
  always_comb begin
    bus.q33_q30 = count_q[15:12];
    bus.q23_q20 = count_q[11:8];
    bus.q13_q10 = count_q[7:4];
    bus.q03_q00 = count_q[3:0];
    bus.busy    = (state_q == StRun);
    bus.done    = (state_q == StDone);
    bus.eu      = (state_q == StRun) && bus.ei && (count_q == 16'h0001);
  end

endmodule

// File: tb/tb_n4_b10_down_timer.sv
// Directed bench for n4_b10_down_timer; inputs change 1 time unit after the
// rising edge and outputs are checked before the next one.
module tb_n4_b10_down_timer;

  logic clock;
  logic reset_;
  int   n_checks;
  int   n_fails;

  n4_b10_down_timer_if bus ();

  n4_b10_down_timer dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  logic [15:0] q;
  assign q = {bus.q33_q30, bus.q23_q20, bus.q13_q10, bus.q03_q00};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic ld, input logic [15:0] d, input logic e);
    bus.load    = ld;
    bus.d33_d30 = d[15:12];
    bus.d23_d20 = d[11:8];
    bus.d13_d10 = d[7:4];
    bus.d03_d00 = d[3:0];
    bus.ei      = e;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] exp_q;
    logic        exp_done;
    logic        exp_busy;
    n_checks = 0;
    n_fails  = 0;
    reset_   = 1'b0;
    set_in(1'b0, 16'h0000, 1'b0);

    // Reset state
    #12;
    check("rst_q", q, 16'h0000);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_done", 16'(bus.done), 16'd0);
    check("rst_eu", 16'(bus.eu), 16'd0);

    // IDLE ignores ei
    @(negedge clock);
    reset_ = 1'b1;
    set_in(1'b0, 16'h0000, 1'b1);
    tick();
    tick();
    check("idle_ei_q", q, 16'h0000);
    check("idle_ei_busy", 16'(bus.busy), 16'd0);

    // Asynchronous reset mid-count
    set_in(1'b1, 16'h0473, 1'b1);
    tick();
    check("ld0473_q", q, 16'h0473);
    check("ld0473_busy", 16'(bus.busy), 16'd1);
    set_in(1'b0, 16'h0000, 1'b0);
    tick();
    check("hold0473_q", q, 16'h0473);
    #2;
    reset_ = 1'b0;
    #1;
    check("arst_q", q, 16'h0000);
    check("arst_busy", 16'(bus.busy), 16'd0);
    check("arst_done", 16'(bus.done), 16'd0);
    #3;
    reset_ = 1'b1;
    set_in(1'b0, 16'h0000, 1'b1);
    tick();
    check("post_rst_q", q, 16'h0000);
    check("post_rst_busy", 16'(bus.busy), 16'd0);

    // Basic countdown from 0012
    set_in(1'b1, 16'h0012, 1'b1);
    tick();
    check("ld0012_q", q, 16'h0012);
    check("ld0012_busy", 16'(bus.busy), 16'd1);
    set_in(1'b0, 16'h0000, 1'b1);
    #1;
    check("cd12_eu", 16'(bus.eu), 16'd0);
    for (int n = 11; n >= 1; n--) begin
      tick();
      check("cd_q", q, bcd(n));
      check("cd_eu", 16'(bus.eu), (n == 1) ? 16'd1 : 16'd0);
      check("cd_busy", 16'(bus.busy), 16'd1);
      check("cd_done", 16'(bus.done), 16'd0);
    end
    tick();
    check("cd_zero_q", q, 16'h0000);
    check("cd_zero_done", 16'(bus.done), 16'd1);
    check("cd_zero_busy", 16'(bus.busy), 16'd0);
    check("cd_zero_eu", 16'(bus.eu), 16'd0);
    tick();
    check("cd_after_done", 16'(bus.done), 16'd0);
`ifdef N4_B10_DOWN_TIMER_AUTORELOAD_EN
    check("cd_after_q", q, 16'h0012);
    check("cd_after_busy", 16'(bus.busy), 16'd1);
`else
    check("cd_after_q", q, 16'h0000);
    check("cd_after_busy", 16'(bus.busy), 16'd0);
`endif

    // Borrow chain and enable gaps
    set_in(1'b1, 16'h1000, 1'b1);
    tick();
    check("ld1000_q", q, 16'h1000);
    set_in(1'b0, 16'h0000, 1'b1);
    tick();
    check("dec1000_q", q, 16'h0999);
    set_in(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_q", q, 16'h0999);
      check("gap_busy", 16'(bus.busy), 16'd1);
    end
    set_in(1'b1, 16'h0100, 1'b1);
    tick();
    check("ld0100_q", q, 16'h0100);
    set_in(1'b0, 16'h0000, 1'b1);
    tick();
    check("dec0100_q", q, 16'h0099);

    // Load priority in RUN and digit sanitising
    set_in(1'b1, 16'h0005, 1'b1);
    tick();
    check("ld0005_q", q, 16'h0005);
    set_in(1'b1, 16'h9F3A, 1'b1);
    tick();
    check("ld9f3a_q", q, 16'h9939);
    check("ld9f3a_busy", 16'(bus.busy), 16'd1);
    set_in(1'b0, 16'h0000, 1'b1);
    tick();
    check("dec9939_q", q, 16'h9938);

    // Zero preset goes straight to DONE, then IDLE
    set_in(1'b1, 16'h0000, 1'b1);
    tick();
    check("ld0000_q", q, 16'h0000);
    check("ld0000_done", 16'(bus.done), 16'd1);
    check("ld0000_busy", 16'(bus.busy), 16'd0);
    set_in(1'b0, 16'h0000, 1'b1);
    tick();
    check("z_idle_done", 16'(bus.done), 16'd0);
    check("z_idle_busy", 16'(bus.busy), 16'd0);
    check("z_idle_q", q, 16'h0000);

    // Load during DONE wins over the DONE exit
    set_in(1'b1, 16'h0000, 1'b0);
    tick();
    check("z2_done", 16'(bus.done), 16'd1);
    set_in(1'b1, 16'h0002, 1'b0);
    tick();
    check("done_ld_q", q, 16'h0002);
    check("done_ld_busy", 16'(bus.busy), 16'd1);
    check("done_ld_done", 16'(bus.done), 16'd0);

    // Autoreload behaviour (single done when the feature is absent)
    set_in(1'b1, 16'h0003, 1'b1);
    tick();
    set_in(1'b0, 16'h0000, 1'b1);
    #1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
`ifdef N4_B10_DOWN_TIMER_AUTORELOAD_EN
      exp_q    = bcd(3 - (i % 4));
      exp_done = ((i % 4) == 3);
      exp_busy = ((i % 4) != 3);
`else
      exp_q    = (i < 3) ? bcd(3 - i) : 16'h0000;
      exp_done = (i == 3);
      exp_busy = (i < 3);
`endif
      check("ar_q", q, exp_q);
      check("ar_done", 16'(bus.done), 16'(exp_done));
      check("ar_busy", 16'(bus.busy), 16'(exp_busy));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/n4_b10_down_timer.md
# n4_b10_down_timer

4-digit BCD presettable down counter (0000–9999) with a small control FSM. Software or a parent block loads a start value; the block then decrements once per enabled cycle, raises `eu` on the step into 0000, and pulses `done` when the count expires. It is the countdown counterpart of the team's cascaded base-10 up counters, and it drives `eu` so that timers can be chained.

## Interface
- No parameters; width is fixed at 4 BCD digits.
- `clock` input 1: rising-edge clock.
- `reset_` input 1: asynchronous active-low reset.
- `load` input 1: preset strobe; has priority over everything except reset.
- `d33_d30`, `d23_d20`, `d13_d10`, `d03_d00` input 4 each: preset digits, thousands to units; sampled when `load`=1.
- `ei` input 1: count enable; one decrement per cycle while running.
- `q33_q30`, `q23_q20`, `q13_q10`, `q03_q00` output 4 each: current count digits; registered.
- `eu` output 1: combinational borrow/terminal indication = (state==RUN) & `ei` & (q==0001).
- `busy` output 1: state==RUN.
- `done` output 1: state==DONE; high for exactly one cycle per expiry.

## Operation
- States: IDLE, RUN, DONE. Registers: 16-bit count, 2-bit state, and (only with the macro) a 16-bit preset copy.
- Reset: count 0000, state IDLE. Outputs after reset: q=0000, `eu`=0, `busy`=0, `done`=0.
- Load sanitising: any preset digit >9 is loaded as 9, per digit, independently.
- `load`=1 in any state: next count = sanitised preset. Next state is RUN if the preset is nonzero, otherwise DONE. `ei` is ignored in that cycle.
- IDLE: count holds and `ei` is ignored.
- RUN with `ei`=0: count holds.
- RUN with `ei`=1: BCD decrement.
  - Units 0→9 borrows from tens, tens 0→9 borrows from hundreds, and so on.
  - If count==0001, the next count is 0000 and the next state is DONE.
- DONE, no load: next state IDLE and count stays 0000. Autoreload is the exception; see Configuration.
- There is no wrap below 0000; RUN is never entered with count 0000.
- Reset mid-operation clears everything immediately (asynchronous). The preset copy is also cleared to 0000.

## Timing
- Load latency: q shows the preset 1 cycle after the edge that samples `load`.
- Decrement latency: 1 cycle per `ei`=1 cycle.
- A preset of N with continuous `ei` behaves as follows:
  - q reaches 0000 N cycles after the first RUN cycle.
  - `eu` is high in the RUN cycle where q==0001.
  - `done` is high in the following cycle.
- `done` and `busy` are never high together.
- `load` during DONE takes priority: the next state is RUN (or DONE for a zero preset), not IDLE.

## Configuration
- Macro: `N4_B10_DOWN_TIMER_AUTORELOAD_EN`.
- Defined:
  - Every `load` also stores the sanitised preset in the preset copy.
  - In DONE without `load`, the count is reloaded from the copy and the next state is RUN, giving a periodic `done` every N+1 enabled-or-DONE cycles.
  - If the copy is 0000, the next state is IDLE instead, so a zero preset never loops.
- Undefined: no preset copy register exists, and DONE always goes to IDLE.

## Test plan
- Reset: assert `reset_`=0 mid-count at 0473 → q=0000, `busy`=0, `done`=0 immediately and asynchronously. After release with `ei`=1 and no load → q stays 0000.
- Basic countdown: load 0012, then `ei`=1 continuously → q runs 0012, 0011, 0010, 0009 … 0001, 0000. `eu` is high only in the 0001 cycle, `done` is high for one cycle, and the block then returns to IDLE holding 0000.
- Borrow chain and enable gaps:
  - Load 1000 with `ei`=1 → next q=0999.
  - Apply `ei`=0 for 3 cycles → q holds 0999.
  - Load 0100 with `ei`=1 → next q=0099.
- Priority and sanitising:
  - Load 9F3A while in RUN at 0005 with `ei`=1 → next q=9939 and state RUN.
  - Load 0000 → next cycle `done`=1, `busy`=0.
- Autoreload (macro defined): load 0003 with continuous `ei` → `done` is high every 4th cycle indefinitely, and q cycles 0003, 0002, 0001, 0000. With the macro undefined, the same stimulus gives a single `done`.
